ofifo: RTL and testbench

- Output FIFO at the south edge of the MAC array: the consumer of the per-column partial sums that the array drives out with per-column valid strobes.
- Columns finish at skewed cycles, so each column is buffered independently. A full row of psums is released only when every column holds at least one entry.
- Read side faces the SFU/testbench. Together with the L0 input FIFO this closes the corelet datapath.

---
 rtl/ofifo_pkg.sv | 16 +
 rtl/ofifo_col.sv | 44 ++++
 rtl/ofifo.sv | 61 ++++++
 tb/tb_ofifo.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/ofifo_pkg.sv
// Shared helpers for the wrap-bit pointer scheme used by the output and L0 FIFOs.
package ofifo_pkg;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) result++;
    return result;
  endfunction

  // One extra MSB distinguishes full from empty when the addresses match.
  function automatic int ptr_width(input int depth);
    return clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ofifo_col.sv
// Single-lane psum FIFO: wrap-bit pointers, head entry exposed combinationally.
module ofifo_col
  import ofifo_pkg::*;
#(
  parameter int psum_bw = 16,
  parameter int depth   = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr,
  input  logic [psum_bw-1:0] wdata,
  input  logic               rd,
  output logic [psum_bw-1:0] head,
  output logic               full,
  output logic               empty
);

  localparam int aw = clog2(depth);
  localparam int pw = ptr_width(depth);

  logic [pw-1:0]      wptr;
  logic [pw-1:0]      rptr;
  logic [psum_bw-1:0] mem [depth];

  assign empty = (wptr == rptr);
  assign full  = (wptr[aw-1:0] == rptr[aw-1:0]) && (wptr[aw] != rptr[aw]);
  assign head  = mem[rptr[aw-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr && !full) wptr <= wptr + pw'(1);
      if (rd && !empty) rptr <= rptr + pw'(1);
    end
  end

  // NOTE: storage has no reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (wr && !full) mem[wptr[aw-1:0]] <= wdata;
  end

endmodule

// File: rtl/ofifo.sv
// Output FIFO at the south edge of the MAC array: per-column lanes, row-wide read.
module ofifo
  import ofifo_pkg::*;
#(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int depth   = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [col*psum_bw-1:0] in,
  input  logic [col-1:0]         wr,
  input  logic                   rd,
  output logic [col*psum_bw-1:0] out,
  output logic                   out_valid,
  output logic                   o_full,
  output logic                   o_ready,
  output logic                   o_valid,
  output logic                   o_overflow
);

  logic [col-1:0]         lane_full;
  logic [col-1:0]         lane_empty;
  logic [col*psum_bw-1:0] head_row;
  logic                   rd_accept;

  // NOTE: flags depend on registered pointers only, so rd/wr never loop back into them.
  assign o_full    = |lane_full;
  assign o_ready   = ~|lane_full;
  assign o_valid   = ~|lane_empty;
  assign rd_accept = rd && o_valid;

  for (genvar gi = 0; gi < col; gi++) begin : g_lane
    ofifo_col #(
      .psum_bw (psum_bw),
      .depth   (depth)
    ) u_lane (
      .clk   (clk),
      .reset (reset),
      .wr    (wr[gi]),
      .wdata (in[gi*psum_bw +: psum_bw]),
      .rd    (rd_accept),
      .head  (head_row[gi*psum_bw +: psum_bw]),
      .full  (lane_full[gi]),
      .empty (lane_empty[gi])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out        <= '0;
      out_valid  <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      out_valid <= rd_accept;
      if (rd_accept) out <= head_row;
      if (|(wr & lane_full)) o_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ofifo.sv
// Randomised scoreboard bench for ofifo against a per-lane queue reference model.
module tb_ofifo;

  localparam int COL   = 8;
  localparam int BW    = 16;
  localparam int DEPTH = 64;
  localparam int RW    = COL * BW;

  logic          clk;
  logic          reset;
  logic [RW-1:0] in;
  logic [COL-1:0] wr;
  logic          rd;
  logic [RW-1:0] out;
  logic          out_valid;
  logic          o_full, o_ready, o_valid, o_overflow;

  ofifo #(.col(COL), .psum_bw(BW), .depth(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .in         (in),
    .wr         (wr),
    .rd         (rd),
    .out        (out),
    .out_valid  (out_valid),
    .o_full     (o_full),
    .o_ready    (o_ready),
    .o_valid    (o_valid),
    .o_overflow (o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: one queue per column, expected rows in order, sticky overflow.
  logic [BW-1:0] lane_q [COL][$];
  logic [RW-1:0] exp_q [$];
  logic [RW-1:0] exp_out;
  bit            model_ovf;

  task automatic check(input string name, input logic [RW-1:0] actual, input logic [RW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic bit model_all_nonempty();
    for (int c = 0; c < COL; c++) if (lane_q[c].size() == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit model_any_full();
    for (int c = 0; c < COL; c++) if (lane_q[c].size() == DEPTH) return 1'b1;
    return 1'b0;
  endfunction

  // Drive one cycle of stimulus, check flags against the pre-edge model, then advance the model.
  task automatic step(input logic [COL-1:0] w, input logic [RW-1:0] d, input logic r);
    bit            accept;
    bit            pre_full [COL];
    logic [RW-1:0] row;
    wr = w; in = d; rd = r;
    check("o_valid",    RW'(o_valid),    RW'(model_all_nonempty()));
    check("o_full",     RW'(o_full),     RW'(model_any_full()));
    check("o_ready",    RW'(o_ready),    RW'(!model_any_full()));
    check("o_overflow", RW'(o_overflow), RW'(model_ovf));
    accept = r && model_all_nonempty();
    for (int c = 0; c < COL; c++) pre_full[c] = (lane_q[c].size() == DEPTH);
    if (accept) begin
      row = '0;
      for (int c = 0; c < COL; c++) row[c*BW +: BW] = lane_q[c].pop_front();
      exp_q.push_back(row);
    end
    for (int c = 0; c < COL; c++) begin
      if (w[c]) begin
        if (pre_full[c]) model_ovf = 1'b1;
        else lane_q[c].push_back(d[c*BW +: BW]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, '0, 1'b0);
  endtask

  function automatic logic [RW-1:0] rand_row();
    logic [RW-1:0] r;
    for (int c = 0; c < COL; c++) r[c*BW +: BW] = BW'($urandom);
    return r;
  endfunction

  function automatic logic [RW-1:0] splat(input logic [BW-1:0] v);
    logic [RW-1:0] r;
    for (int c = 0; c < COL; c++) r[c*BW +: BW] = v;
    return r;
  endfunction

  // Assert reset mid-cycle, check the immediate effect, release mid-cycle, realign.
  task automatic mid_reset();
    #3;
    reset = 1'b0;
    wr = '0; rd = 1'b0; in = '0;
    for (int c = 0; c < COL; c++) lane_q[c].delete();
    exp_q.delete();
    exp_out   = '0;
    model_ovf = 1'b0;
    #1;
    check("rst_o_valid",   RW'(o_valid),   '0);
    check("rst_o_full",    RW'(o_full),    '0);
    check("rst_o_ready",   RW'(o_ready),   RW'(1));
    check("rst_out_valid", RW'(out_valid), '0);
    check("rst_out",       out,            '0);
    @(posedge clk);
    @(posedge clk);
    #3;
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every presented row with the scoreboard; otherwise out must hold.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("out_valid_unexpected", RW'(out_valid), '0);
      end else begin
        exp_out = exp_q.pop_front();
        check("out_row", out, exp_out);
      end
    end else begin
      check("out_hold", out, exp_out);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [RW-1:0] d;
    reset = 1'b0; wr = '0; rd = 1'b0; in = '0;
    exp_out = '0; model_ovf = 1'b0;
    #12;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Idle after reset, reads against empty lanes are ignored.
    for (int i = 0; i < 3; i++) step('0, rand_row(), 1'b1);
    idle(2);

    // Skewed fill: one column per cycle, row only visible after column 7.
    for (int c = 0; c < COL; c++) begin
      d = rand_row();
      d[c*BW +: BW] = BW'(16'h0100 + c);
      step(COL'(1) << c, d, 1'b0);
    end
    step('0, '0, 1'b1);
    idle(3);

    // Fill all lanes, drain in order, three times to wrap the pointers.
    for (int pass = 0; pass < 3; pass++) begin
      for (int r = 0; r < DEPTH; r++) step('1, splat(BW'(r)), 1'b0);
      idle(1);
      for (int r = 0; r < DEPTH; r++) step('0, '0, 1'b1);
      idle(2);
    end

    // Overflow on lane 3 while the other lanes keep accepting.
    for (int r = 0; r < DEPTH; r++) step(8'h08, splat(BW'(r + 1000)), 1'b0);
    d = rand_row();
    d[3*BW +: BW] = 16'hDEAD;
    step('1, d, 1'b0);
    idle(2);
    step('0, '0, 1'b1);
    for (int i = 0; i < 5; i++) step('0, '0, 1'b1);
    idle(2);
    mid_reset();

    // Full lanes: read accepted alongside dropped writes.
    for (int r = 0; r < DEPTH; r++) step('1, rand_row(), 1'b0);
    step('1, rand_row(), 1'b1);
    for (int r = 0; r < DEPTH; r++) step('0, '0, 1'b1);
    idle(2);
    mid_reset();

    // Half full: simultaneous read and write keep occupancy and order.
    for (int r = 0; r < DEPTH / 2; r++) step('1, rand_row(), 1'b0);
    for (int r = 0; r < 20; r++) step('1, rand_row(), 1'b1);
    for (int r = 0; r < DEPTH / 2; r++) step('0, '0, 1'b1);
    idle(2);

    // Random traffic with skewed per-column writes.
    for (int i = 0; i < 800; i++) begin
      logic [COL-1:0] w;
      w = COL'($urandom);
      step(w, rand_row(), ($urandom_range(0, 3) == 0));
    end
    for (int r = 0; r < DEPTH + 2; r++) step('0, '0, 1'b1);
    idle(2);

    // Reset with 10 rows buffered, then reads must find nothing.
    for (int r = 0; r < 10; r++) step('1, rand_row(), 1'b0);
    mid_reset();
    for (int i = 0; i < 4; i++) step('0, '0, 1'b1);
    step('1, rand_row(), 1'b0);
    step('0, '0, 1'b1);
    idle(3);

    check("scoreboard_empty", RW'(exp_q.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
